// File: rtl/mult_ctrl_param.sv
// -----------------------------------------------------------------------------
// mult_ctrl_param
//
// Control unit for an iterative shift-add multiplier datapath built from an
// A:B register pair, an X sign/carry flop and a (WIDTH+1)-bit adder/subtractor.
// A bit counter walks the WIDTH iterations, so one set of states covers any
// operand width. Each iteration is an optional OP cycle (add or subtract S
// into A when the multiplier LSB is 1) followed by a SHIFT cycle.
//
// In signed mode the last iteration subtracts instead of adds, because the
// MSB of a two's-complement multiplier carries negative weight. In unsigned
// mode X holds the adder carry-out and the shift fills from it.
//
// With SKIP_ZERO=1, an iteration whose multiplier bit is 0 goes straight to
// SHIFT and saves one cycle.
//
// Parameters:
//   WIDTH      operand width / iteration count (2..32)
//   SKIP_ZERO  1 = skip the OP cycle when M=0
//
// Ports:
//   Clk           in   rising-edge clock
//   Reset         in   synchronous, active-high reset
//   ClearA_LoadB  in   active-low: clear A/X and load B (IDLE only)
//   Run           in   active-low: start a multiply (IDLE only)
//   Signed_Mode   in   1 = two's-complement, 0 = unsigned; captured in CLR
//   M             in   multiplier LSB from the datapath
//   Ld_B          out  clear A and X, load B
//   Clr_XA        out  clear X and A at the start of a run
//   Add           out  A <= A + S
//   Sub           out  A <= A - S (signed mode, last iteration only)
//   Shift_En      out  arithmetic right shift of X:A:B
//   Busy          out  high from CLR through the last SHIFT
//   Done          out  high in HOLD, until Run is released
//   Count         out  current iteration index
// -----------------------------------------------------------------------------
module mult_ctrl_param #(
    parameter int WIDTH     = 8,
    parameter int SKIP_ZERO = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     ClearA_LoadB,
    input  logic                     Run,
    input  logic                     Signed_Mode,
    input  logic                     M,
    output logic                     Ld_B,
    output logic                     Clr_XA,
    output logic                     Add,
    output logic                     Sub,
    output logic                     Shift_En,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(WIDTH)-1:0] Count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        OP,
        SHIFT,
        HOLD
    } state_t;

    state_t state, state_next;
    logic   mode_q;
    logic   last_iter;
    logic   skip_op;

    assign last_iter = (Count == LAST);

    // Skipping is decided from M as the datapath currently presents it.
    // During SHIFT, that is the bit that will be at B[0] after this shift.
    assign skip_op = (SKIP_ZERO != 0) && !M;

    // ------------------------------------------------------------------
    // State, iteration counter and captured mode
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            Count  <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == CLR) begin
                Count  <= '0;
                // Mode is frozen for the whole run.
                mode_q <= Signed_Mode;
            end else if (state == SHIFT && !last_iter) begin
                Count <= Count + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // Load takes priority when both buttons are pressed.
                if (!ClearA_LoadB)
                    state_next = LOAD;
                else if (!Run)
                    state_next = CLR;
            end
            LOAD:
                state_next = IDLE;
            CLR:
                state_next = skip_op ? SHIFT : OP;
            OP:
                state_next = SHIFT;
            SHIFT: begin
                // The last shift always leaves, so Count never wraps.
                if (last_iter)
                    state_next = HOLD;
                else
                    state_next = skip_op ? SHIFT : OP;
            end
            HOLD: begin
                // Wait for Run to be released, so one press gives one multiply.
                if (Run)
                    state_next = IDLE;
            end
            default:
                state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: Moore, except Add/Sub, which follow M while in OP
    // ------------------------------------------------------------------
    always_comb begin
        Ld_B     = 1'b0;
        Clr_XA   = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD:
                Ld_B = 1'b1;
            CLR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            OP: begin
                Busy = 1'b1;
                if (M) begin
                    // In signed mode the multiplier MSB has weight -2^(WIDTH-1).
                    if (mode_q && last_iter)
                        Sub = 1'b1;
                    else
                        Add = 1'b1;
                end
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            HOLD:
                Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mult_ctrl_param.md
# mult_ctrl_param

Parametrised control unit for the iterative shift-add multiplier datapath (A:B register pair, X sign flop, (WIDTH+1)-bit adder/subtractor). It sequences load, clear, add/subtract and shift for any operand width using a bit counter instead of unrolled states. It adds several features:
- runtime signed/unsigned mode;
- optional skipping of add cycles when M=0;
- a Done/Busy handshake, including a hold state until Run is released.

## Interface
Parameters:
- WIDTH, 8, operand width in bits, 2..32; iteration count.
- SKIP_ZERO, 0, 1: when M=0, skip the OP cycle and go straight to SHIFT.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- ClearA_LoadB  in  1  active-low, already synchronised/debounced: clear A/X, load B from switches.
- Run  in  1  active-low, already synchronised/debounced: start a multiply.
- Signed_Mode  in  1  1 = two's-complement multiply, 0 = unsigned; captured in CLR.
- M  in  1  current multiplier LSB (B[0]) from datapath.
- Ld_B  out  1  active-high: clear A and X, load B (one cycle).
- Clr_XA  out  1  active-high: clear X and A (one cycle, start of run).
- Add  out  1  active-high: A <= A + S (sign-extended per mode).
- Sub  out  1  active-high: A <= A − S (signed mode, last iteration only).
- Shift_En  out  1  active-high: arithmetic right shift of X:A:B.
- Busy  out  1  high from CLR through the last SHIFT.
- Done  out  1  high in HOLD.
- Count  out  $clog2(WIDTH)  current iteration index (debug/visibility).

## Operation
States: IDLE, LOAD, CLR, OP, SHIFT, HOLD.

Transitions:
- **IDLE:**
  - ClearA_LoadB=0 → LOAD.
  - Else Run=0 → CLR.
  - Both low: LOAD wins.
- **LOAD → IDLE.**
- **CLR:**
  - Count <= 0.
  - Capture Signed_Mode into mode_q.
  - Next state: OP, or SHIFT if SKIP_ZERO=1 and M=0.
- **OP → SHIFT.**
- **SHIFT:**
  - If Count == WIDTH−1 → HOLD.
  - Else Count <= Count+1, next state OP, or SHIFT if SKIP_ZERO=1 and M=0. M here is the value after the current shift, as presented by the datapath in the same cycle.
- **HOLD:**
  - Run=1 (released) → IDLE.
  - Else stay. One press yields exactly one multiply.

Outputs:
- Outputs are Moore, except Add/Sub, which are combinational on M in OP.
- IDLE: all outputs 0.
- LOAD: Ld_B=1.
- CLR: Clr_XA=1, Busy=1.
- OP:
  - Busy=1.
  - If M=1: Sub=1 when mode_q=1 and Count==WIDTH−1; otherwise Add=1.
  - If M=0: Add=Sub=0.
- SHIFT: Shift_En=1, Busy=1.
- HOLD: Done=1.
- Add and Sub are never simultaneously 1.
- Unsigned mode (mode_q=0): Sub is never asserted.
  - X is the adder carry-out; the datapath zero-extends S.
  - The shift fills from X.

Rules:
- Signed_Mode changes during Busy are ignored.
- Run/ClearA_LoadB are ignored outside IDLE/HOLD.
- Reset in any state:
  - next cycle state IDLE, Count=0, mode_q=0, all outputs 0;
  - any in-progress multiply is abandoned;
  - datapath contents are not cleared by this block.

## Timing
- Reset values: state IDLE, Count 0, mode_q 0, every output 0.
- Run sampled low in IDLE at edge t:
  - CLR during cycle t+1.
  - With SKIP_ZERO=0: OP_i at t+2+2i, SHIFT_i at t+3+2i.
  - HOLD (Done=1) from cycle t+2+2·WIDTH.
  - Busy high for 1+2·WIDTH cycles (17 for WIDTH=8).
- SKIP_ZERO=1: each M=0 iteration costs 1 cycle instead of 2.
  - Latency = 1 + WIDTH + (number of 1-bits seen in M) cycles, then HOLD.
- LOAD lasts exactly one cycle. Holding ClearA_LoadB low repeats IDLE→LOAD every 2 cycles (reload is idempotent).
- Count wraps are impossible: SHIFT at WIDTH−1 always exits to HOLD.

## Test plan
- **Reset:** assert Reset 3 cycles mid-run (in OP, Count=4) → next cycle all outputs 0, Count=0, Busy=0; a fresh Run then completes normally.
- **Signed 8-bit, SKIP_ZERO=0, B=0x07 (M sequence 1,1,1,0,0,0,0,0):**
  - Busy exactly 17 cycles.
  - Add pulses in OP_0..2.
  - No Sub (last M=0).
  - 8 Shift_En pulses, then Done=1 until Run released.
  - Datapath product for S=−3 (0xFD): 0xFFEB.
- **Signed, B=0x80 (M=1 only on last iteration):** single Sub in OP_7, no Add. With S=0x02, product 0xFF00 (−256).
- **Unsigned, same B=0x80, S=0x02:** Add (not Sub) in OP_7, product 0x0100.
- **SKIP_ZERO=1, WIDTH=8, B=0x01:** Busy for 10 cycles (1 CLR + 1 OP + 8 SHIFT).
- **Priority and one-shot:**
  - Run and ClearA_LoadB both low in IDLE → LOAD (Ld_B=1), no Busy.
  - Holding Run low through HOLD for 20 cycles → only one multiply; a second multiply starts only after Run goes high and then low again.
